// File: rtl/matrix_pkg.sv
// Shared matrix accelerator definitions: loader FSM states and default bus widths
// used by the loader, the accelerator and the input RAM instances.
package matrix_pkg;

  localparam int MATRIX_DATA_WIDTH = 64;
  localparam int MATRIX_ADDR_WIDTH = 4;
  localparam int TIMEOUT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } loader_state_t;

endpackage

// File: rtl/matrix_loader_if.sv
// Valid/ready operand-word stream feeding the matrix loader.
interface matrix_loader_if #(
  parameter int DATA_WIDTH = matrix_pkg::MATRIX_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/mm_timeout_ctr.sv
// Clearable, enabled up-counter; tc flags the increment that reaches LIMIT.
module mm_timeout_ctr #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/matrix_loader.sv
// Loads WORDS stream words into the input RAM, starts the accelerator and waits for done.
// Optional MATRIX_LOADER_CKSUM_EN adds a running XOR checksum output of the current job.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH   = MATRIX_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MATRIX_ADDR_WIDTH,
  parameter int WORDS        = 16,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_loader_if.slave        in_if,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  load_active,
  output logic                  comp_enb,
  input  logic                  acc_done,
  output logic                  busy,
  output logic                  job_done,
  output logic                  err_short,
  output logic                  err_timeout
`ifdef MATRIX_LOADER_CKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] cksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORDS - 1);

  loader_state_t         state, state_next;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic                  xfer;
  logic                  final_word;
  logic                  early_last;
  logic                  in_wait;
  logic                  tmo_tc;

  // word_cnt is 0 whenever the FSM is in IDLE, so it doubles as the write address.
  assign in_if.in_ready = !rst && (state == IDLE || state == LOAD);
  assign xfer           = in_if.in_valid && in_if.in_ready;
  assign final_word     = (word_cnt == LAST_IDX);
  assign early_last     = xfer && in_if.in_last && !final_word;
  assign in_wait        = (state == WAIT);
  assign busy           = (state != IDLE);
  assign load_active    = (state == LOAD) || mem_we;

  // NOTE: default assigned first so no branch leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE, LOAD: begin
        if (xfer) begin
          if (final_word)          state_next = START;
          else if (in_if.in_last)  state_next = IDLE;
          else                     state_next = LOAD;
        end
      end
      START:   state_next = WAIT;
      WAIT:    if (acc_done || tmo_tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      comp_enb    <= 1'b0;
      job_done    <= 1'b0;
      err_short   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      mem_we   <= xfer;
      comp_enb <= (state == START);
      job_done <= in_wait && acc_done;
      if (xfer) begin
        mem_addr  <= word_cnt;
        mem_wdata <= in_if.in_data;
        word_cnt  <= (final_word || in_if.in_last) ? '0 : word_cnt + 1'b1;
      end
      // A new job clears the sticky flags; a same-cycle early in_last re-sets err_short.
      if (xfer && state == IDLE) begin
        err_short   <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (early_last) err_short <= 1'b1;
      if (in_wait && tmo_tc && !acc_done) err_timeout <= 1'b1;
    end
  end

  mm_timeout_ctr #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (DONE_TIMEOUT)
  ) u_timeout_ctr (
    .clk (clk),
    .rst (rst),
    .clr (!in_wait),
    .en  (in_wait),
    .tc  (tmo_tc)
  );

`ifdef MATRIX_LOADER_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cksum <= '0;
    end else if (xfer) begin
      cksum <= (state == IDLE) ? in_if.in_data : (cksum ^ in_if.in_data);
    end
  end
`endif

endmodule
